// File: rtl/forward_converter_pipe_32769_32768_32767.sv
// Binary-to-RNS forward converter for moduli {2^15+1, 2^15, 2^15-1}; 3-stage pipeline.
// Latency 3 cycles; one global stall: every stage holds while out_valid & ~out_ready.
module forward_converter_pipe_32769_32768_32767 #(
    parameter int N = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     out_x1,
    output logic [N-1:0]   out_x2,
    output logic [N-1:0]   out_x3,
    output logic           out_of_range
);
    localparam int unsigned M1 = (1 << N) + 1;
    localparam int unsigned M3 = (1 << N) - 1;
    localparam logic [3*N-1:0] M_RANGE  = {{(2*N){1'b1}}, {N{1'b0}}};
    localparam logic [N+1:0]   C_M1_17  = (N+2)'(M1);
    localparam logic [N+1:0]   C_2M1_17 = (N+2)'(2 * M1);
    localparam logic [N:0]     C_M1_16  = (N+1)'(M1);
    localparam logic [N:0]     C_M3_16  = (N+1)'(M3);
    localparam logic [N-1:0]   C_M3_15  = N'(M3);

    logic en;

    // stage 1
    logic           v1_q;
    logic [N+1:0]   s3_q, s3_d, t1_q, t1_d;
    logic [N-1:0]   a0_1_q;
    logic           oor_1_q, oor_1_d;
    // stage 2
    logic           v2_q;
    logic [N:0]     u_q, u_d, p1_q, p1_d;
    logic [N-1:0]   a0_2_q;
    logic           oor_2_q;
    // stage 3 / outputs
    logic           v3_q;
    logic [N:0]     x1_q, x1_d;
    logic [N-1:0]   x2_q, x3_q, x3_d;
    logic           oor_3_q;

    assign en       = ~v3_q | out_ready;
    assign in_ready = en;

    always_comb begin
        s3_d    = {2'b00, in_data[N-1:0]} + {2'b00, in_data[2*N-1:N]} + {2'b00, in_data[3*N-1:2*N]};
        // bias by M1 so the difference never goes negative
        t1_d    = {2'b00, in_data[N-1:0]} + {2'b00, in_data[3*N-1:2*N]} + C_M1_17
                  - {2'b00, in_data[2*N-1:N]};
        oor_1_d = (in_data >= M_RANGE);

        u_d = {1'b0, s3_q[N-1:0]} + {{(N-1){1'b0}}, s3_q[N+1:N]};
        // 16-bit wraparound is exact here because each true result is below 2^16
        if (t1_q >= C_2M1_17) begin
            p1_d = t1_q[N:0] - C_2M1_17[N:0];
        end else if (t1_q >= C_M1_17) begin
            p1_d = t1_q[N:0] - C_M1_16;
        end else begin
            p1_d = t1_q[N:0];
        end

        x1_d = (p1_q >= C_M1_16) ? (p1_q - C_M1_16) : p1_q;
        x3_d = (u_q >= C_M3_16) ? (u_q[N-1:0] - C_M3_15) : u_q[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s3_q    <= '0;
            t1_q    <= '0;
            a0_1_q  <= '0;
            oor_1_q <= 1'b0;
            v2_q    <= 1'b0;
            u_q     <= '0;
            p1_q    <= '0;
            a0_2_q  <= '0;
            oor_2_q <= 1'b0;
            v3_q    <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            oor_3_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                s3_q    <= s3_d;
                t1_q    <= t1_d;
                a0_1_q  <= in_data[N-1:0];
                oor_1_q <= oor_1_d;
            end
            u_q     <= u_d;
            p1_q    <= p1_d;
            a0_2_q  <= a0_1_q;
            oor_2_q <= oor_1_q;
            // bubbles never disturb the visible outputs
            if (v2_q) begin
                x1_q    <= x1_d;
                x2_q    <= a0_2_q;
                x3_q    <= x3_d;
                oor_3_q <= oor_2_q;
            end
        end
    end

    assign out_valid    = v3_q;
    assign out_x1       = x1_q;
    assign out_x2       = x2_q;
    assign out_x3       = x3_q;
    assign out_of_range = oor_3_q;

endmodule
